// File: rtl/m6809_pkg.sv
// Shared types and constants for the 6809 interrupt entry sequencer:
// FSM states, vector addresses, push postbytes, CCR bit positions, source codes.
package m6809_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETE   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_MASK   = 3'd4,
    ST_VEC_HI = 3'd5,
    ST_VEC_LO = 3'd6
  } state_e;

  localparam logic [15:0] VEC_NMI  = 16'hFFFC;
  localparam logic [15:0] VEC_SWI  = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ  = 16'hFFF8;
  localparam logic [15:0] VEC_FIRQ = 16'hFFF6;
  localparam logic [15:0] VEC_SWI2 = 16'hFFF4;
  localparam logic [15:0] VEC_SWI3 = 16'hFFF2;

  localparam logic [7:0] PB_FULL = 8'hFF;
  localparam logic [7:0] PB_FIRQ = 8'h81;
  localparam logic [7:0] OP_PSHS = 8'h34;

  localparam int CCR_E = 7;
  localparam int CCR_F = 6;
  localparam int CCR_I = 4;

  localparam logic [2:0] SRC_NMI  = 3'd0;
  localparam logic [2:0] SRC_SWI  = 3'd1;
  localparam logic [2:0] SRC_IRQ  = 3'd2;
  localparam logic [2:0] SRC_FIRQ = 3'd3;
  localparam logic [2:0] SRC_SWI2 = 3'd4;
  localparam logic [2:0] SRC_SWI3 = 3'd5;

  function automatic logic [15:0] vector_of(input logic [2:0] src);
    logic [15:0] v;
    case (src)
      SRC_NMI:  v = VEC_NMI;
      SRC_SWI:  v = VEC_SWI;
      SRC_IRQ:  v = VEC_IRQ;
      SRC_FIRQ: v = VEC_FIRQ;
      SRC_SWI2: v = VEC_SWI2;
      default:  v = VEC_SWI3;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/m6809_core_intseq_prio.sv
// Combinational exception selector: SWI request beats NMI latch beats
// unmasked FIRQ beats unmasked IRQ; hardware sources only at a boundary.
module m6809_int_prio
  import m6809_pkg::*;
(
  input  logic       swi_req_i,
  input  logic [1:0] swi_sel_i,
  input  logic       inst_boundary_i,
  input  logic       nmi_pend_i,
  input  logic       firq_b_i,
  input  logic       irq_b_i,
  input  logic [7:0] ccr_i,
  output logic       valid_o,
  output logic [2:0] src_o,
  output logic       full_o
);

  always_comb begin
    valid_o = 1'b0;
    src_o   = SRC_SWI;
    full_o  = 1'b1;
    if (swi_req_i) begin
      valid_o = 1'b1;
      case (swi_sel_i)
        2'd2:    src_o = SRC_SWI2;
        2'd3:    src_o = SRC_SWI3;
        default: src_o = SRC_SWI;
      endcase
    end else if (inst_boundary_i) begin
      if (nmi_pend_i) begin
        valid_o = 1'b1;
        src_o   = SRC_NMI;
      end else if (!firq_b_i && !ccr_i[CCR_F]) begin
        valid_o = 1'b1;
        src_o   = SRC_FIRQ;
        full_o  = 1'b0;
      end else if (!irq_b_i && !ccr_i[CCR_I]) begin
        valid_o = 1'b1;
        src_o   = SRC_IRQ;
      end
    end
  end

endmodule

// File: rtl/m6809_core_intseq.sv
// Interrupt / SWI entry sequencer: set E, push state, mask, fetch vector, load PC.
// Build option M6809_NMI_ARM_EN: ignore NMI edges until nmi_arm has been seen high.
module m6809_core_intseq
  import m6809_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        nmi_b,
  input  logic        firq_b,
  input  logic        irq_b,
  input  logic        swi_req,
  input  logic [1:0]  swi_sel,
  input  logic        inst_boundary,
  input  logic        nmi_arm,
  input  logic [7:0]  ccr_in,
  input  logic [7:0]  din,
  input  logic        rm_busy,
  output logic        core_hold,
  output logic        rm_start,
  output logic [7:0]  rm_ir,
  output logic        rm_ir_oe,
  output logic [7:0]  pb_out,
  output logic        pb_oe,
  output logic [15:0] addr,
  output logic        bus_oe,
  output logic [7:0]  ccr_out,
  output logic        ccr_out_en,
  output logic [15:0] pc_out,
  output logic        pc_out_en,
  output logic        int_ack,
  output logic [2:0]  int_src,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  logic [2:0]  src_q, src_d;
  logic        full_q, full_d;
  logic [7:0]  hi_q, hi_d;
  logic        nmi_prev_q, nmi_lat_q, nmi_lat_d;
  logic        arm_ok, accept;
  logic        p_valid, p_full;
  logic [2:0]  p_src;
  logic [7:0]  mask_ccr;
  logic [15:0] vec;

`ifdef M6809_NMI_ARM_EN
  logic arm_q;
  always_ff @(posedge clk) begin
    if (!reset_b) arm_q <= 1'b0;
    else          arm_q <= arm_q | nmi_arm;
  end
  assign arm_ok = arm_q;
`else
  logic unused_nmi_arm;
  assign unused_nmi_arm = nmi_arm;
  assign arm_ok = 1'b1;
`endif

  m6809_int_prio u_prio (
    .swi_req_i       (swi_req),
    .swi_sel_i       (swi_sel),
    .inst_boundary_i (inst_boundary),
    .nmi_pend_i      (nmi_lat_q),
    .firq_b_i        (firq_b),
    .irq_b_i         (irq_b),
    .ccr_i           (ccr_in),
    .valid_o         (p_valid),
    .src_o           (p_src),
    .full_o          (p_full)
  );

  // A fresh edge wins over the clear so an edge in the accept cycle is not lost.
  always_comb begin
    nmi_lat_d = nmi_lat_q;
    if (nmi_prev_q && !nmi_b && arm_ok)      nmi_lat_d = 1'b1;
    else if (accept && p_src == SRC_NMI)     nmi_lat_d = 1'b0;
  end

  always_comb begin
    mask_ccr = ccr_in;
    if (src_q != SRC_SWI2 && src_q != SRC_SWI3) mask_ccr[CCR_I] = 1'b1;
    if (src_q == SRC_NMI || src_q == SRC_SWI || src_q == SRC_FIRQ) mask_ccr[CCR_F] = 1'b1;
  end

  assign vec       = vector_of(src_q);
  assign core_hold = (state_q != ST_IDLE);
  assign rm_ir     = OP_PSHS;
  assign dbg_state = state_q;

  // Handshake with the register-move unit: rm_start is a one-cycle request
  // issued in START; the unit owns the bus while rm_busy=1 and we wait in WAIT
  // until the first cycle it reports rm_busy=0.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    full_d     = full_q;
    hi_d       = hi_q;
    accept     = 1'b0;
    rm_start   = 1'b0;
    rm_ir_oe   = 1'b0;
    pb_out     = 8'h00;
    pb_oe      = 1'b0;
    addr       = 16'h0000;
    bus_oe     = 1'b0;
    ccr_out    = 8'h00;
    ccr_out_en = 1'b0;
    pc_out     = 16'h0000;
    pc_out_en  = 1'b0;
    int_ack    = 1'b0;
    int_src    = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (p_valid) begin
          accept  = 1'b1;
          src_d   = p_src;
          full_d  = p_full;
          state_d = ST_SETE;
        end
      end
      ST_SETE: begin
        ccr_out        = ccr_in;
        ccr_out[CCR_E] = full_q;
        ccr_out_en     = 1'b1;
        state_d        = ST_START;
      end
      ST_START: begin
        rm_start = 1'b1;
        pb_oe    = 1'b1;
        rm_ir_oe = 1'b1;
        pb_out   = full_q ? PB_FULL : PB_FIRQ;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        rm_ir_oe = 1'b1;
        if (!rm_busy) state_d = ST_MASK;
      end
      ST_MASK: begin
        ccr_out    = mask_ccr;
        ccr_out_en = (mask_ccr != ccr_in);
        state_d    = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        bus_oe  = 1'b1;
        addr    = vec;
        hi_d    = din;
        state_d = ST_VEC_LO;
      end
      ST_VEC_LO: begin
        bus_oe    = 1'b1;
        addr      = vec + 16'd1;
        pc_out    = {hi_q, din};
        pc_out_en = 1'b1;
        int_ack   = 1'b1;
        int_src   = src_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q    <= ST_IDLE;
      src_q      <= 3'd0;
      full_q     <= 1'b0;
      hi_q       <= 8'h00;
      nmi_prev_q <= 1'b1;
      nmi_lat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      full_q     <= full_d;
      hi_q       <= hi_d;
      nmi_prev_q <= nmi_b;
      nmi_lat_q  <= nmi_lat_d;
    end
  end

endmodule

// File: tb/tb_m6809_core_intseq.sv
// Directed bench for the interrupt entry sequencer; models the vector ROM,
// the register-move busy window and the core CCR register.
module tb_m6809_core_intseq;
  import m6809_pkg::*;

  logic        clk = 1'b0;
  logic        reset_b, nmi_b, firq_b, irq_b, swi_req, inst_boundary, nmi_arm, rm_busy;
  logic [1:0]  swi_sel;
  logic [7:0]  ccr_in, din;
  logic        core_hold, rm_start, rm_ir_oe, pb_oe, bus_oe, ccr_out_en, pc_out_en, int_ack;
  logic [7:0]  rm_ir, pb_out, ccr_out;
  logic [15:0] addr, pc_out;
  logic [2:0]  int_src;
  state_e      dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  m6809_core_intseq dut (
    .clk(clk), .reset_b(reset_b), .nmi_b(nmi_b), .firq_b(firq_b), .irq_b(irq_b),
    .swi_req(swi_req), .swi_sel(swi_sel), .inst_boundary(inst_boundary), .nmi_arm(nmi_arm),
    .ccr_in(ccr_in), .din(din), .rm_busy(rm_busy), .core_hold(core_hold),
    .rm_start(rm_start), .rm_ir(rm_ir), .rm_ir_oe(rm_ir_oe), .pb_out(pb_out), .pb_oe(pb_oe),
    .addr(addr), .bus_oe(bus_oe), .ccr_out(ccr_out), .ccr_out_en(ccr_out_en),
    .pc_out(pc_out), .pc_out_en(pc_out_en), .int_ack(int_ack), .int_src(int_src),
    .dbg_state(dbg_state)
  );

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFF2: return 8'h56;  16'hFFF3: return 8'h78;
      16'hFFF4: return 8'hDE;  16'hFFF5: return 8'hF0;
      16'hFFF6: return 8'hC0;  16'hFFF7: return 8'h00;
      16'hFFF8: return 8'h12;  16'hFFF9: return 8'h34;
      16'hFFFA: return 8'h9A;  16'hFFFB: return 8'hBC;
      16'hFFFC: return 8'hAB;  16'hFFFD: return 8'hCD;
      default:  return 8'hEE;
    endcase
  endfunction

  assign din = mem_rd(addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with cycle-0 (accept) inputs applied; returns in the cycle after VEC_LO.
  task automatic run_seq(input string tag, input int exp_start, input logic [7:0] exp_pb,
                         input int exp_pc_cyc, input logic [15:0] exp_pc, input logic [2:0] exp_src,
                         input logic [15:0] exp_vec, input logic [7:0] exp_sete,
                         input logic [7:0] exp_ccr, input int exp_nccr, input int nmi_fall);
    int busy_left, start_cyc, pc_cyc, n_ccr, conflicts;
    logic [7:0]  pb_s, ir_s, sete_s, ccr_next;
    logic [15:0] vec_s, pc_s;
    logic [2:0]  src_s;
    logic        h0, h1, done;
    busy_left = 0; start_cyc = -1; pc_cyc = -1; n_ccr = 0; conflicts = 0;
    pb_s = 0; ir_s = 0; sete_s = 0; vec_s = 0; pc_s = 0; src_s = 0; h0 = 0; h1 = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      rm_busy = (busy_left > 0);
      #1;
      if (c == 0) h0 = core_hold;
      if (c == 1) h1 = core_hold;
      if (rm_start && start_cyc < 0) begin
        start_cyc = c; pb_s = pb_out; ir_s = rm_ir_oe ? rm_ir : 8'h00;
      end
      if (ccr_out_en) begin
        if (n_ccr == 0) sete_s = ccr_out;
        n_ccr++;
      end
      if (bus_oe && vec_s == 16'h0000) vec_s = addr;
      if ((bus_oe && rm_busy) || (ccr_out_en && pc_out_en)) conflicts++;
      if (pc_out_en && int_ack) begin
        pc_cyc = c; pc_s = pc_out; src_s = int_src; done = 1'b1;
      end
      ccr_next = ccr_out_en ? ccr_out : ccr_in;
      if (rm_start) busy_left = (pb_out == 8'hFF) ? 12 : 3;
      else if (busy_left > 0) busy_left--;
      step();
      ccr_in  = ccr_next;
      swi_req = 1'b0;
      rm_busy = 1'b0;
      if (nmi_fall >= 0 && c + 1 == nmi_fall) nmi_b = 1'b0;
      if (nmi_fall >= 0 && c + 1 == nmi_fall + 2) nmi_b = 1'b1;
    end
    check({tag, " done"},     32'(done), 32'd1);
    check({tag, " hold_c0"},  32'(h0), 32'd0);
    check({tag, " hold_c1"},  32'(h1), 32'd1);
    check({tag, " start_cyc"}, 32'(start_cyc), 32'(exp_start));
    check({tag, " postbyte"}, 32'(pb_s), 32'(exp_pb));
    check({tag, " rm_ir"},    32'(ir_s), 32'h34);
    check({tag, " sete_ccr"}, 32'(sete_s), 32'(exp_sete));
    check({tag, " vector"},   32'(vec_s), 32'(exp_vec));
    check({tag, " pc_cyc"},   32'(pc_cyc), 32'(exp_pc_cyc));
    check({tag, " pc"},       32'(pc_s), 32'(exp_pc));
    check({tag, " src"},      32'(src_s), 32'(exp_src));
    check({tag, " ccr_wr"},   32'(n_ccr), 32'(exp_nccr));
    check({tag, " ccr_end"},  32'(ccr_in), 32'(exp_ccr));
    check({tag, " overlap"},  32'(conflicts), 32'd0);
  endtask

  initial begin
    reset_b = 1'b0; nmi_b = 1'b1; firq_b = 1'b1; irq_b = 1'b1; swi_req = 1'b0;
    swi_sel = 2'd0; inst_boundary = 1'b0; nmi_arm = 1'b0; rm_busy = 1'b0; ccr_in = 8'h00;
    repeat (3) step();
    check("rst hold",   32'(core_hold), 32'd0);
    check("rst state",  32'(dbg_state), 32'(ST_IDLE));
    check("rst rm_ir",  32'(rm_ir), 32'h34);
    check("rst strobes", 32'({rm_start, rm_ir_oe, pb_oe, bus_oe, ccr_out_en, pc_out_en, int_ack}), 32'd0);
    reset_b = 1'b1;
    step();

    // NMI edge straight after reset, before any arm
    inst_boundary = 1'b1;
    nmi_b = 1'b0;
    step();
    nmi_b = 1'b1;
`ifdef M6809_NMI_ARM_EN
    repeat (3) step();
    check("arm gate hold", 32'(core_hold), 32'd0);
    nmi_arm = 1'b1;
    step();
    nmi_arm = 1'b0;
    step();
    check("arm no retro", 32'(core_hold), 32'd0);
`else
    run_seq("nmi_boot", 2, 8'hFF, 18, 16'hABCD, SRC_NMI, 16'hFFFC, 8'h80, 8'hD0, 2, -1);
`endif

    // IRQ with an NMI edge arriving during WAIT, then NMI at the next boundary
    ccr_in = 8'h00; irq_b = 1'b0;
    run_seq("irq", 2, 8'hFF, 18, 16'h1234, SRC_IRQ, 16'hFFF8, 8'h80, 8'h90, 2, 5);
    run_seq("nmi_after_irq", 2, 8'hFF, 18, 16'hABCD, SRC_NMI, 16'hFFFC, 8'h90, 8'hD0, 2, -1);
    irq_b = 1'b1;
    step();

    // NMI latched and IRQ low in the same accept cycle
    ccr_in = 8'h00; inst_boundary = 1'b0; nmi_b = 1'b0; irq_b = 1'b0;
    step();
    nmi_b = 1'b1; inst_boundary = 1'b1;
    run_seq("nmi_vs_irq", 2, 8'hFF, 18, 16'hABCD, SRC_NMI, 16'hFFFC, 8'h80, 8'hD0, 2, -1);
    repeat (3) step();
    check("irq masked after nmi", 32'(core_hold), 32'd0);
    ccr_in = 8'h00;
    run_seq("irq_after_rti", 2, 8'hFF, 18, 16'h1234, SRC_IRQ, 16'hFFF8, 8'h80, 8'h90, 2, -1);
    irq_b = 1'b1;
    step();

    // FIRQ partial entry
    ccr_in = 8'h00; firq_b = 1'b0;
    run_seq("firq", 2, 8'h81, 9, 16'hC000, SRC_FIRQ, 16'hFFF6, 8'h00, 8'h50, 2, -1);
    firq_b = 1'b1;
    step();

    // Software interrupts
    ccr_in = 8'h00; inst_boundary = 1'b0; swi_req = 1'b1; swi_sel = 2'd3;
    run_seq("swi3", 2, 8'hFF, 18, 16'h5678, SRC_SWI3, 16'hFFF2, 8'h80, 8'h80, 1, -1);
    ccr_in = 8'h00; swi_req = 1'b1; swi_sel = 2'd1;
    run_seq("swi", 2, 8'hFF, 18, 16'h9ABC, SRC_SWI, 16'hFFFA, 8'h80, 8'hD0, 2, -1);
    ccr_in = 8'h00; inst_boundary = 1'b1; irq_b = 1'b0; swi_req = 1'b1; swi_sel = 2'd2;
    run_seq("swi2_over_irq", 2, 8'hFF, 18, 16'hDEF0, SRC_SWI2, 16'hFFF4, 8'h80, 8'h80, 1, -1);
    irq_b = 1'b1;
    step();

    // Reset while waiting on the register-move unit
    ccr_in = 8'h00; irq_b = 1'b0; rm_busy = 1'b1;
    repeat (4) step();
    check("wait state", 32'(dbg_state), 32'(ST_WAIT));
    reset_b = 1'b0;
    step();
    reset_b = 1'b1; irq_b = 1'b1; rm_busy = 1'b0;
    #1;
    check("post rst state", 32'(dbg_state), 32'(ST_IDLE));
    check("post rst strobes", 32'({core_hold, rm_start, rm_ir_oe, pb_oe, bus_oe, ccr_out_en, pc_out_en, int_ack}), 32'd0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
